fp_div_result_queue: RTL and testbench

Downstream capture stage for the single-precision FP divider. Registers each result strobed out of the divider, classifies it (zero/inf/NaN/denormal), and buffers it in a small FIFO. Results are handed to the consumer over a valid/ready handshake. The divider has no backpressure input, so overflow is detected and reported, never stalled.

---
 rtl/fp_pkg.sv | 39 +++
 rtl/fp_div_result_queue_if.sv | 42 ++++
 rtl/fp32_classify.sv | 45 ++++
 rtl/fp_div_result_queue.sv | 133 +++++++++++++
 tb/tb_fp_div_result_queue.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// ----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the single-precision FP divider result path:
//   - IEEE-754 single field positions (sign / exponent / mantissa)
//   - special exponent value and exponent bias
//   - result flag bit indices and the flag vector type
//   - queue occupancy state type
// Ports: none (package).
// ----------------------------------------------------------------------------
package fp_pkg;

    // FP32 field positions
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_MSB = 22;
    localparam int MANT_LSB = 0;
    localparam int EXP_W    = EXP_MSB - EXP_LSB + 1;
    localparam int MANT_W   = MANT_MSB - MANT_LSB + 1;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [EXP_W-1:0] BIAS    = 8'd127;

    // Flag bit indices within fp_flags_t
    localparam int FLG_ZERO   = 0;
    localparam int FLG_INF    = 1;
    localparam int FLG_NAN    = 2;
    localparam int FLG_DENORM = 3;

    typedef logic [3:0] fp_flags_t;

    // Occupancy of the result queue, decoded from the entry count
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;

endpackage

// File: rtl/fp_div_result_queue_if.sv
// ----------------------------------------------------------------------------
// fp_div_result_queue_if
// Bundles the divider-side strobe, the consumer valid/ready handshake and the
// status/sideband signals of fp_div_result_queue.
//   div_out/div_valid      : result word and per-cycle strobe from the divider
//   out_data/out_flags     : head-of-queue result and its classification flags
//   out_valid/out_ready    : consumer handshake
//   count                  : occupied entries
//   drop_err/drop_clr      : sticky overflow indication and its clear
// Modports:
//   slave  - the queue itself (consumes div_*, produces out_*)
//   master - the surrounding environment (divider + consumer)
// ----------------------------------------------------------------------------
interface fp_div_result_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
);
    import fp_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] div_out;
    logic              div_valid;
    logic [DATA_W-1:0] out_data;
    fp_flags_t         out_flags;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     count;
    logic              drop_err;
    logic              drop_clr;

    modport slave (
        input  div_out, div_valid, out_ready, drop_clr,
        output out_data, out_flags, out_valid, count, drop_err
    );

    modport master (
        output div_out, div_valid, out_ready, drop_clr,
        input  out_data, out_flags, out_valid, count, drop_err
    );

endinterface

// File: rtl/fp32_classify.sv
// ----------------------------------------------------------------------------
// fp32_classify
// Combinational classifier for an IEEE-754 single word.
//   word_in  : candidate result {sign, exp[7:0], mant[22:0]}
//   flags    : [0] zero, [1] inf, [2] NaN, [3] denormal (one-hot or all-zero)
//   word_out : word_in, except denormals are flushed to a zero of the same sign
// ----------------------------------------------------------------------------
module fp32_classify
    import fp_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word_in,
    output fp_flags_t         flags,
    output logic [DATA_W-1:0] word_out
);

    logic [EXP_W-1:0]  exp_f;
    logic [MANT_W-1:0] mant_f;

    assign exp_f  = word_in[EXP_MSB:EXP_LSB];
    assign mant_f = word_in[MANT_MSB:MANT_LSB];

    // Exponent all-zeros splits into zero/denormal, all-ones into inf/NaN;
    // every other exponent is a normal number and raises no flag.
    always_comb begin
        flags    = '0;
        word_out = word_in;
        if (exp_f == '0) begin
            if (mant_f == '0) begin
                flags[FLG_ZERO] = 1'b1;
            end else begin
                flags[FLG_DENORM] = 1'b1;
                word_out          = {word_in[SIGN_BIT], {(DATA_W-1){1'b0}}};
            end
        end else if (exp_f == EXP_MAX) begin
            if (mant_f == '0) begin
                flags[FLG_INF] = 1'b1;
            end else begin
                flags[FLG_NAN] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_div_result_queue.sv
// ----------------------------------------------------------------------------
// fp_div_result_queue
// Capture stage behind the single-precision FP divider. Every div_valid cycle
// delivers one result which is written into a DEPTH-entry FIFO and presented
// to the consumer with a fall-through valid/ready handshake. The divider
// cannot be stalled, so a result arriving while the queue is full and not
// draining is discarded and recorded in the sticky drop_err flag.
//
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous, active-low reset
//   bus   : fp_div_result_queue_if.slave (div_out/div_valid, out_data,
//           out_flags, out_valid/out_ready, count, drop_err/drop_clr)
//
// Build option:
//   FP_DIV_FLAG_CHECK_EN - when defined, results are classified through
//   fp32_classify, flags are stored per entry and denormals are flushed to
//   signed zero. When undefined, data is stored unmodified and out_flags is 0.
// ----------------------------------------------------------------------------
module fp_div_result_queue
    import fp_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fp_div_result_queue_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic              drop_err_q;
    occ_state_t        occ;
    logic              do_push;
    logic              do_pop;
    logic              do_drop;
    logic [DATA_W-1:0] wr_data;

    logic [DATA_W-1:0] data_mem [DEPTH];

    always_comb begin
        occ = OCC_PARTIAL;
        if (count_q == '0) begin
            occ = OCC_EMPTY;
        end else if (count_q == DEPTH_C) begin
            occ = OCC_FULL;
        end
    end

    // A pop frees the slot that a same-cycle push reuses, so a full queue
    // still accepts a result as long as the consumer is draining it.
    always_comb begin
        do_pop  = (occ != OCC_EMPTY) && bus.out_ready;
        do_push = bus.div_valid && ((occ != OCC_FULL) || do_pop);
        do_drop = bus.div_valid && (occ == OCC_FULL) && !do_pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A drop in the same cycle as drop_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err_q <= 1'b0;
        end else if (do_drop) begin
            drop_err_q <= 1'b1;
        end else if (bus.drop_clr) begin
            drop_err_q <= 1'b0;
        end
    end

`ifdef FP_DIV_FLAG_CHECK_EN
    fp_flags_t cls_flags;
    fp_flags_t flag_mem [DEPTH];

    fp32_classify #(
        .DATA_W (DATA_W)
    ) u_classify (
        .word_in  (bus.div_out),
        .flags    (cls_flags),
        .word_out (wr_data)
    );

    always_ff @(posedge clk) begin
        if (do_push) begin
            data_mem[wr_ptr] <= wr_data;
            flag_mem[wr_ptr] <= cls_flags;
        end
    end

    assign bus.out_flags = (occ != OCC_EMPTY) ? flag_mem[rd_ptr] : '0;
`else
    assign wr_data = bus.div_out;

    always_ff @(posedge clk) begin
        if (do_push) begin
            data_mem[wr_ptr] <= wr_data;
        end
    end

    assign bus.out_flags = '0;
`endif

    // Storage is not reset, so the head is masked to zero while empty.
    assign bus.out_data  = (occ != OCC_EMPTY) ? data_mem[rd_ptr] : '0;
    assign bus.out_valid = (occ != OCC_EMPTY);
    assign bus.count     = count_q;
    assign bus.drop_err  = drop_err_q;

endmodule

// File: tb/tb_fp_div_result_queue.sv
// ----------------------------------------------------------------------------
// tb_fp_div_result_queue
// Self-checking bench for fp_div_result_queue (DEPTH=4, DATA_W=32). Directed
// scenarios plus a randomized run compared against a queue-based reference
// model. Follows FP_DIV_FLAG_CHECK_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_fp_div_result_queue;
    import fp_pkg::*;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fp_div_result_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

    fp_div_result_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: queue of stored entries plus the sticky drop flag
    logic [31:0] mq_data [$];
    logic [3:0]  mq_flags [$];
    logic        m_drop;

    // Reference classification from the IEEE field rules; returns {flags, data}
    function automatic logic [35:0] ref_entry(input logic [31:0] w);
        int          e;
        int          m;
        logic [3:0]  f;
        logic [31:0] d;
        e = int'(w[30:23]);
        m = int'(w[22:0]);
        f = 4'b0000;
        d = w;
`ifdef FP_DIV_FLAG_CHECK_EN
        if (e == 0 && m == 0)        f = 4'b0001;
        else if (e == 255 && m == 0) f = 4'b0010;
        else if (e == 255)           f = 4'b0100;
        else if (e == 0) begin
            f = 4'b1000;
            d = w & 32'h8000_0000;
        end
`endif
        return {f, d};
    endfunction

    // Drives one cycle starting at a negedge, updates the model at the
    // posedge and returns at the following negedge with inputs idle.
    task automatic drive_cycle(input logic v, input logic [31:0] d,
                               input logic r, input logic c);
        bit          pop;
        bit          push;
        bit          drop;
        logic [35:0] ent;
        bus.div_valid = v;
        bus.div_out   = d;
        bus.out_ready = r;
        bus.drop_clr  = c;
        pop  = (mq_data.size() > 0) && r;
        push = v && ((mq_data.size() < DEPTH) || pop);
        drop = v && !push;
        @(posedge clk);
        if (rst_n) begin
            if (pop) begin
                mq_data.delete(0);
                mq_flags.delete(0);
            end
            if (push) begin
                ent = ref_entry(d);
                mq_data.push_back(ent[31:0]);
                mq_flags.push_back(ent[35:32]);
            end
            if (drop)   m_drop = 1'b1;
            else if (c) m_drop = 1'b0;
        end
        @(negedge clk);
        bus.div_valid = 1'b0;
        bus.div_out   = '0;
        bus.out_ready = 1'b0;
        bus.drop_clr  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mq_data.delete();
        mq_flags.delete();
        m_drop = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.div_valid = 1'b1;
        bus.div_out   = 32'h3F80_0000;
        bus.out_ready = 1'b0;
        bus.drop_clr  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.count !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_count: got %0d expected 0", bus.count);
        end
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_flags !== 4'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_head: got valid=%b data=%h flags=%b expected 0/0/0",
                     bus.out_valid, bus.out_data, bus.out_flags);
        end
        tests_run++;
        if (bus.drop_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_drop: got %b expected 0", bus.drop_err);
        end
        bus.div_valid = 1'b0;
        do_reset();
    endtask

    task automatic test_single_push();
        drive_cycle(1'b1, 32'h3F80_0000, 1'b1, 1'b0);
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h3F80_0000 ||
            bus.out_flags !== 4'b0000 || bus.count !== 3'd1) begin
            tests_failed++;
            $display("[TB] FAIL single_push: got valid=%b data=%h flags=%b count=%0d expected 1/3f800000/0000/1",
                     bus.out_valid, bus.out_data, bus.out_flags, bus.count);
        end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL single_pop: got valid=%b count=%0d expected 0/0",
                     bus.out_valid, bus.count);
        end
    endtask

    task automatic test_fill_overflow();
        logic [31:0] vals [5];
        vals = '{32'h4000_0000, 32'h4020_0000, 32'h4040_0000, 32'h4060_0000, 32'h4080_0000};
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, vals[i], 1'b0, 1'b0);
        tests_run++;
        if (bus.count !== 3'd4 || bus.drop_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL overflow: got count=%0d drop=%b expected 4/1", bus.count, bus.drop_err);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== vals[i]) begin
                tests_failed++;
                $display("[TB] FAIL overflow_pop%0d: got valid=%b data=%h expected 1/%h",
                         i, bus.out_valid, bus.out_data, vals[i]);
            end
            drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        end
        tests_run++;
        if (bus.count !== 3'd0 || bus.drop_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL overflow_drained: got count=%0d drop=%b expected 0/1", bus.count, bus.drop_err);
        end
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        tests_run++;
        if (bus.drop_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL drop_clr: got %b expected 0", bus.drop_err);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] vals [4];
        logic [31:0] expect_seq [4];
        vals       = '{32'h4100_0000, 32'h4110_0000, 32'h4120_0000, 32'h4130_0000};
        expect_seq = '{32'h4110_0000, 32'h4120_0000, 32'h4130_0000, 32'hC120_0000};
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, vals[i], 1'b0, 1'b0);
        drive_cycle(1'b1, 32'hC120_0000, 1'b1, 1'b0);
        tests_run++;
        if (bus.count !== 3'd4 || bus.drop_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL full_push_pop: got count=%0d drop=%b expected 4/0", bus.count, bus.drop_err);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (bus.out_data !== expect_seq[i]) begin
                tests_failed++;
                $display("[TB] FAIL full_order%0d: got %h expected %h", i, bus.out_data, expect_seq[i]);
            end
            drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_classification();
`ifdef FP_DIV_FLAG_CHECK_EN
        localparam int N = 6;
        logic [31:0] vin  [N] = '{32'h7FC0_0000, 32'hFF80_0000, 32'h8000_0000,
                                  32'h8000_0001, 32'h0040_0000, 32'h3F80_0000};
        logic [31:0] dexp [N] = '{32'h7FC0_0000, 32'hFF80_0000, 32'h8000_0000,
                                  32'h8000_0000, 32'h0000_0000, 32'h3F80_0000};
        logic [3:0]  fexp [N] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b1000, 4'b0000};
`else
        localparam int N = 3;
        logic [31:0] vin  [N] = '{32'h8000_0001, 32'h7FC0_0000, 32'h0040_0000};
        logic [31:0] dexp [N] = '{32'h8000_0001, 32'h7FC0_0000, 32'h0040_0000};
        logic [3:0]  fexp [N] = '{4'b0000, 4'b0000, 4'b0000};
`endif
        for (int i = 0; i < N; i++) begin
            drive_cycle(1'b1, vin[i], 1'b0, 1'b0);
            tests_run++;
            if (bus.out_data !== dexp[i] || bus.out_flags !== fexp[i]) begin
                tests_failed++;
                $display("[TB] FAIL classify_%h: got data=%h flags=%b expected %h/%b",
                         vin[i], bus.out_data, bus.out_flags, dexp[i], fexp[i]);
            end
            drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'h4200_0000 + i, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        mq_data.delete();
        mq_flags.delete();
        m_drop = 1'b0;
        #1;
        tests_run++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.drop_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got count=%0d valid=%b drop=%b expected 0/0/0",
                     bus.count, bus.out_valid, bus.drop_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_cycle(1'b1, 32'h4049_0FDB, 1'b0, 1'b0);
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h4049_0FDB || bus.count !== 3'd1) begin
            tests_failed++;
            $display("[TB] FAIL after_reset: got valid=%b data=%h count=%0d expected 1/40490fdb/1",
                     bus.out_valid, bus.out_data, bus.count);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] exp_data;
        logic [3:0]  exp_flags;
        int          errs;
        errs = 0;
        for (int n = 0; n < 400; n++) begin
            exp_data  = (mq_data.size() > 0) ? mq_data[0]  : 32'h0;
            exp_flags = (mq_data.size() > 0) ? mq_flags[0] : 4'h0;
            tests_run++;
            if (bus.out_valid !== (mq_data.size() > 0) || bus.out_data !== exp_data ||
                bus.out_flags !== exp_flags || int'(bus.count) != mq_data.size() ||
                bus.drop_err !== m_drop) begin
                tests_failed++;
                errs++;
                if (errs <= 10)
                    $display("[TB] FAIL random_%0d: got v=%b d=%h f=%b c=%0d e=%b expected v=%b d=%h f=%b c=%0d e=%b",
                             n, bus.out_valid, bus.out_data, bus.out_flags, bus.count, bus.drop_err,
                             (mq_data.size() > 0), exp_data, exp_flags, mq_data.size(), m_drop);
            end
            d = $urandom;
            case ($urandom_range(0, 5))
                0: d = d & 32'h8000_0000;
                1: d = (d & 32'h8000_0000) | 32'h7F80_0000;
                2: d = (d & 32'h807F_FFFF) | 32'h7F80_0001;
                3: d = (d & 32'h807F_FFFF) | 32'h0000_0001;
                default: ;
            endcase
            drive_cycle($urandom_range(0, 9) < 7, d, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 9) == 0);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.div_valid = 1'b0;
        bus.div_out   = '0;
        bus.out_ready = 1'b0;
        bus.drop_clr  = 1'b0;
        m_drop        = 1'b0;
        test_reset();
        test_single_push();
        test_fill_overflow();
        test_full_push_pop();
        test_classification();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
